// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared defaults and state encoding for the RAM controller FSM
package ram_ctrl_pkg;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 32;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    RDWAIT = 3'd3,
    CLEAR  = 3'd4
  } state_t;
endpackage

// File: rtl/ram_ctrl_fsm.sv
// ram_ctrl_fsm: single-port RAM controller with request/response client port and zero-fill sequencer
module ram_ctrl_fsm import ram_ctrl_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              clr_start,
  output logic              clr_done,
  output logic              busy,
  output logic              ram_cs,
  output logic              ram_wr,
  output logic              ram_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt, w_cnt, w_addr;
  logic [DATA_W-1:0] w_din, w_rdata;
  logic              w_xfer, w_last, w_cs, w_wr, w_oe, w_done, w_rsp, w_busy;

  assign req_ready = rst_n && r_state == IDLE && !clr_start;
  assign w_xfer    = req_valid && req_ready;
  assign w_last    = r_cnt == ADDR_W'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      ram_cs    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      clr_done  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      ram_cs    <= w_cs;
      ram_wr    <= w_wr;
      ram_oe    <= w_oe;
      ram_addr  <= w_addr;
      ram_din   <= w_din;
      rsp_valid <= w_rsp;
      rsp_rdata <= w_rdata;
      clr_done  <= w_done;
      busy      <= w_busy;
    end
  end

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = clr_start ? CLEAR : w_xfer ? (req_wr ? WRITE : READ) : IDLE;
      READ:    w_next = RDWAIT;
      CLEAR:   w_next = w_last ? IDLE : CLEAR;
      default: w_next = IDLE;
    endcase
  end

  // Output flops load the values belonging to the state being entered.
  always_comb begin
    w_busy  = w_next != IDLE;
    w_cs    = w_busy;
    w_wr    = w_next == WRITE || w_next == CLEAR;
    w_oe    = w_next == READ || w_next == RDWAIT;
    w_cnt   = w_next != CLEAR ? r_cnt : r_state == CLEAR ? r_cnt + 1'b1 : '0;
    w_addr  = w_next == CLEAR ? w_cnt : w_xfer ? req_addr : ram_addr;
    w_din   = w_next == CLEAR ? '0 : (w_xfer && req_wr) ? req_wdata : ram_din;
    w_done  = r_state == CLEAR && w_next == IDLE;
    w_rsp   = r_state == RDWAIT;
    w_rdata = r_state == RDWAIT ? ram_dout : rsp_rdata;
  end
endmodule

// File: tb/tb_ram_ctrl_fsm.sv
// tb_ram_ctrl_fsm: randomized scenario bench for ram_ctrl_fsm against an array-based RAM reference
module tb_ram_ctrl_fsm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_wr = 1'b0, clr_start = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, clr_done, busy, ram_cs, ram_wr, ram_oe;
  logic [7:0] rsp_rdata, ram_din, ram_dout;
  logic [4:0] ram_addr;
  logic [7:0] mem [32];
  logic [7:0] ref_mem [32];
  int         n_chk = 0, n_pass = 0, cyc = 0;

  ram_ctrl_fsm dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .clr_start(clr_start), .clr_done(clr_done), .busy(busy), .ram_cs(ram_cs), .ram_wr(ram_wr),
    .ram_oe(ram_oe), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (ram_cs && ram_wr) mem[ram_addr] <= ram_din;
  assign ram_dout = ram_oe ? mem[ram_addr] : 8'h00;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) step;
    n_chk++; if ({req_ready, busy, ram_cs, ram_wr, ram_oe, rsp_valid, clr_done} !== 7'b0) $display("FAIL reset_ctrl got %b exp 0000000", {req_ready, busy, ram_cs, ram_wr, ram_oe, rsp_valid, clr_done}); else n_pass++;
    n_chk++; if ({ram_addr, ram_din, rsp_rdata} !== 21'b0) $display("FAIL reset_data got %h exp 0", {ram_addr, ram_din, rsp_rdata}); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL reset_release_ready got %b exp 1", req_ready); else n_pass++;
  endtask

  task automatic test_write(input logic [4:0] a, input logic [7:0] d);
    req_valid = 1'b1; req_wr = 1'b1; req_addr = a; req_wdata = d;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL wr_ready got %b exp 1", req_ready); else n_pass++;
    step;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
    #1;
    n_chk++; if ({ram_cs, ram_wr, ram_oe, busy, req_ready} !== 5'b11010) $display("FAIL wr_ctrl got %b exp 11010", {ram_cs, ram_wr, ram_oe, busy, req_ready}); else n_pass++;
    n_chk++; if (ram_addr !== a || ram_din !== d) $display("FAIL wr_bus got %h/%h exp %h/%h", ram_addr, ram_din, a, d); else n_pass++;
    step;
    n_chk++; if ({ram_cs, ram_wr, busy} !== 3'b000 || ram_addr !== a || ram_din !== d) $display("FAIL wr_after got %b %h/%h exp 000 %h/%h", {ram_cs, ram_wr, busy}, ram_addr, ram_din, a, d); else n_pass++;
    ref_mem[a] = d;
  endtask

  task automatic test_read(input logic [4:0] a);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = a;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rd_ready got %b exp 1", req_ready); else n_pass++;
    step;
    req_valid = 1'b0; req_addr = $urandom;
    n_chk++; if ({ram_cs, ram_wr, ram_oe, rsp_valid} !== 4'b1010 || ram_addr !== a) $display("FAIL rd_c1 got %b %h exp 1010 %h", {ram_cs, ram_wr, ram_oe, rsp_valid}, ram_addr, a); else n_pass++;
    step;
    n_chk++; if ({ram_cs, ram_wr, ram_oe, rsp_valid} !== 4'b1010 || ram_addr !== a) $display("FAIL rd_c2 got %b %h exp 1010 %h", {ram_cs, ram_wr, ram_oe, rsp_valid}, ram_addr, a); else n_pass++;
    step;
    n_chk++; if ({ram_cs, ram_oe, rsp_valid} !== 3'b001 || rsp_rdata !== ref_mem[a]) $display("FAIL rd_rsp addr %h got %b %h exp 001 %h", a, {ram_cs, ram_oe, rsp_valid}, rsp_rdata, ref_mem[a]); else n_pass++;
    step;
    n_chk++; if (rsp_valid !== 1'b0 || rsp_rdata !== ref_mem[a]) $display("FAIL rd_hold got %b %h exp 0 %h", rsp_valid, rsp_rdata, ref_mem[a]); else n_pass++;
  endtask

  task automatic test_fill;
    int last, waitc;
    last = 0;
    req_valid = 1'b1; req_wr = 1'b1;
    for (int i = 0; i < 31; i++) begin
      req_addr = 5'(i); req_wdata = 8'(2 * i);
      #1;
      waitc = 0;
      while (!req_ready && waitc < 8) begin step; waitc++; end
      n_chk++; if (req_ready !== 1'b1) $display("FAIL fill_timeout i=%0d got %b exp 1", i, req_ready); else n_pass++;
      if (i > 0) begin
        n_chk++; if (cyc - last != 2) $display("FAIL fill_gap i=%0d got %0d exp 2", i, cyc - last); else n_pass++;
      end
      last = cyc;
      step;
      n_chk++; if (ram_addr !== 5'(i) || ram_din !== 8'(2 * i) || ram_wr !== 1'b1) $display("FAIL fill_bus i=%0d got %h/%h exp %h/%h", i, ram_addr, ram_din, 5'(i), 8'(2 * i)); else n_pass++;
      ref_mem[i] = 8'(2 * i);
    end
    req_valid = 1'b0;
    step;
    test_read(5'd30);
  endtask

  task automatic test_clr_ignored;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 5'd3; req_wdata = 8'h3C;
    step;
    req_valid = 1'b0; clr_start = 1'b1;
    step;
    clr_start = 1'b0;
    n_chk++; if ({busy, ram_cs} !== 2'b00) $display("FAIL clr_ignored got %b exp 00", {busy, ram_cs}); else n_pass++;
    ref_mem[3] = 8'h3C;
    test_read(5'd3);
  endtask

  task automatic test_clear;
    clr_start = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL clr_ready got %b exp 0", req_ready); else n_pass++;
    step;
    clr_start = 1'b0;
    for (int k = 0; k < 32; k++) begin
      n_chk++; if ({ram_cs, ram_wr, ram_oe, busy, clr_done} !== 5'b11010 || ram_addr !== 5'(k) || ram_din !== 8'h00) $display("FAIL clr_cycle k=%0d got %b %h/%h exp 11010 %h/00", k, {ram_cs, ram_wr, ram_oe, busy, clr_done}, ram_addr, ram_din, 5'(k)); else n_pass++;
      step;
    end
    n_chk++; if ({clr_done, busy, ram_cs} !== 3'b100 || ram_addr !== 5'd31) $display("FAIL clr_done got %b %h exp 100 1f", {clr_done, busy, ram_cs}, ram_addr); else n_pass++;
    step;
    n_chk++; if (clr_done !== 1'b0) $display("FAIL clr_done_pulse got %b exp 0", clr_done); else n_pass++;
    for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;
    test_read(5'($urandom_range(0, 31)));
  endtask

  task automatic test_collision;
    int  waitc;
    logic saw_oe;
    test_write(5'd9, 8'h77);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 5'd9; clr_start = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b0) $display("FAIL col_ready got %b exp 0", req_ready); else n_pass++;
    step;
    clr_start = 1'b0;
    n_chk++; if ({busy, ram_wr, ram_oe} !== 3'b110) $display("FAIL col_enter got %b exp 110", {busy, ram_wr, ram_oe}); else n_pass++;
    waitc = 0; saw_oe = 1'b0;
    while (!clr_done && waitc < 40) begin saw_oe |= ram_oe; step; waitc++; end
    n_chk++; if (clr_done !== 1'b1 || waitc != 32) $display("FAIL col_clear got done=%b after %0d exp 1 after 32", clr_done, waitc); else n_pass++;
    n_chk++; if (saw_oe !== 1'b0) $display("FAIL col_early_read got %b exp 0", saw_oe); else n_pass++;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL col_ready_after got %b exp 1", req_ready); else n_pass++;
    for (int k = 0; k < 32; k++) ref_mem[k] = 8'h00;
    step;
    req_valid = 1'b0;
    n_chk++; if (ram_oe !== 1'b1 || ram_addr !== 5'd9) $display("FAIL col_read got %b %h exp 1 09", ram_oe, ram_addr); else n_pass++;
    step; step;
    n_chk++; if (rsp_valid !== 1'b1 || rsp_rdata !== ref_mem[9]) $display("FAIL col_rsp got %b %h exp 1 %h", rsp_valid, rsp_rdata, ref_mem[9]); else n_pass++;
    step;
  endtask

  task automatic test_reset_mid_clear;
    int waitc;
    test_write(5'd12, 8'h5A);
    test_read(5'd12);
    clr_start = 1'b1;
    step;
    clr_start = 1'b0;
    waitc = 0;
    while (ram_addr !== 5'd10 && waitc < 40) begin step; waitc++; end
    n_chk++; if (ram_addr !== 5'd10 || busy !== 1'b1) $display("FAIL rmc_reach got %h %b exp 0a 1", ram_addr, busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++; if ({req_ready, busy, ram_cs, ram_wr, ram_oe, rsp_valid, clr_done} !== 7'b0 || {ram_addr, ram_din, rsp_rdata} !== 21'b0) $display("FAIL rmc_zero got %b %h exp 0 0", {req_ready, busy, ram_cs, ram_wr, ram_oe, rsp_valid, clr_done}, {ram_addr, ram_din, rsp_rdata}); else n_pass++;
    for (int k = 0; k < 10; k++) ref_mem[k] = 8'h00;
    repeat (3) begin
      step;
      n_chk++; if ({clr_done, busy} !== 2'b00) $display("FAIL rmc_hold got %b exp 00", {clr_done, busy}); else n_pass++;
    end
    rst_n = 1'b1;
    #1;
    n_chk++; if (req_ready !== 1'b1) $display("FAIL rmc_ready got %b exp 1", req_ready); else n_pass++;
    step;
    n_chk++; if ({clr_done, busy, ram_cs} !== 3'b000) $display("FAIL rmc_after got %b exp 000", {clr_done, busy, ram_cs}); else n_pass++;
    test_read(5'd12);
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      if ($urandom_range(0, 1) == 1) test_write(5'($urandom), 8'($urandom));
      else test_read(5'($urandom));
    end
  endtask

  initial begin
    test_reset;
    test_write(5'd5, 8'hA5);
    test_read(5'd5);
    test_fill;
    test_clr_ignored;
    test_clear;
    test_collision;
    test_reset_mid_clear;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ram_ctrl_fsm.md
RAM_CTRL_FSM -- requirements
Module: ram_ctrl_fsm

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 5, meaning RAM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning RAM data width.
REQ-003 The block SHALL have parameter DEPTH, default 32, meaning number of RAM locations (2**ADDR_W).
REQ-004 The block SHALL use one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 req_valid  input  1  client request present.
REQ-008 req_ready  output  1  block accepts a request this cycle.
REQ-009 req_wr  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  request address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  one-cycle pulse, read data valid.
REQ-013 rsp_rdata  output  DATA_W  read data, held until next read response.
REQ-014 clr_start  input  1  one-cycle pulse, zero-fill the whole RAM.
REQ-015 clr_done  output  1  one-cycle pulse at end of zero-fill.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 ram_cs, ram_wr, ram_oe  output  1 each  RAM chip select, write enable, output enable.
REQ-018 ram_addr  output  ADDR_W;  ram_din  output  DATA_W;  ram_dout  input  DATA_W  RAM port signals.

Function
REQ-019 The FSM SHALL have states IDLE, WRITE, READ, RDWAIT and CLEAR.
REQ-020 All ram_* outputs, rsp_valid, rsp_rdata, clr_done and busy SHALL be driven directly from flops.
REQ-021 req_ready SHALL equal (state==IDLE) && !clr_start; a request transfers on a rising edge where req_valid && req_ready.
REQ-022 Write transfer: WRITE for exactly one cycle with ram_cs=1, ram_wr=1, ram_oe=0, ram_addr=req_addr, ram_din=req_wdata; then IDLE.
REQ-023 Read transfer: READ then RDWAIT, one cycle each, with ram_cs=1, ram_wr=0, ram_oe=1, ram_addr=req_addr held across both.
REQ-024 rsp_rdata SHALL capture ram_dout at the edge that leaves RDWAIT; rsp_valid SHALL be high in the following cycle only (3 cycles after the transfer edge).
REQ-025 Responses SHALL have no backpressure; at most one request is outstanding.
REQ-026 Outside WRITE, READ, RDWAIT and CLEAR, ram_cs, ram_wr and ram_oe SHALL be 0; ram_addr and ram_din SHALL hold their last values.
REQ-027 clr_start in IDLE SHALL enter CLEAR; it SHALL win over a simultaneous req_valid, which is not accepted and stays pending.
REQ-028 clr_start outside IDLE SHALL be ignored.
REQ-029 CLEAR SHALL write 0 to addresses 0..DEPTH-1, ascending, one per cycle (ram_cs=1, ram_wr=1, ram_oe=0).
REQ-030 After the write to DEPTH-1, the counter SHALL NOT wrap; the FSM SHALL return to IDLE with clr_done high for that one cycle.
REQ-031 The sequence SHALL be DEPTH CLEAR cycles followed by one clr_done cycle.
REQ-032 Addresses SHALL be used modulo 2**ADDR_W; no range error is reported.

Reset
REQ-033 On rst_n low, the FSM SHALL go to IDLE immediately and asynchronously.
REQ-034 On rst_n low, every output flop SHALL be cleared to 0, including rsp_rdata, ram_addr, ram_din and the clear counter.
REQ-035 Reset during WRITE, READ, RDWAIT or CLEAR SHALL abort the operation with no rsp_valid and no clr_done.
REQ-036 req_ready SHALL be 0 while rst_n is low.

Structure
REQ-037 A shared package ram_ctrl_pkg SHALL hold ADDR_W, DATA_W and DEPTH defaults and the state encoding (IDLE=0, WRITE=1, READ=2, RDWAIT=3, CLEAR=4).
REQ-038 The design SHALL be a single flat FSM plus address counter; no sub-module.

Verification
REQ-039 Write: req_wr=1, addr=5, wdata=0xA5 -> next cycle only: ram_cs=1, ram_wr=1, ram_addr=5, ram_din=0xA5; req_ready low for that cycle.
REQ-040 Read: RAM model holds 0xA5 at addr 5, read addr 5 -> ram_oe=1 for 2 cycles, rsp_valid 3 cycles after transfer, rsp_rdata=0xA5.
REQ-041 Fill: req_valid held, writes addr i=0..30, data 2*i -> one accepted every 2 cycles; read-back of addr 30 returns 60.
REQ-042 Clear: clr_start pulse -> 32 writes, addr 0..31, data 0; clr_done on cycle 33; busy high cycles 1..32.
REQ-043 Collision: clr_start with a read pending -> clear runs first; read accepted in the cycle after clr_done; returns 0.
REQ-044 Reset mid-clear at addr 10 -> all outputs 0 at once, no clr_done; after release, req_ready=1.
